// File: rtl/decoder_param_reg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_param_reg
// Description : Registered N-to-2**N code decoder with valid/ready handshake.
//               Modes: one-hot, thermometer, and multi-beat walking-one scan.
//               An illegal mode is reported as a one-cycle err pulse.
//               N is intended for the range 1..6.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_param_reg #(
    parameter  int N = 3,
    localparam int W = 2**N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [1:0]   mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         out_last,
    output logic         err
);

    localparam logic [1:0]   c_MODE_ONEHOT = 2'b00;
    localparam logic [1:0]   c_MODE_THERM  = 2'b01;
    localparam logic [1:0]   c_MODE_SCAN   = 2'b10;
    localparam logic [W-1:0] c_ONE         = W'(1);
    localparam logic [N-1:0] c_ZERO_N      = '0;

    // OUT holds a single or final beat; SCAN holds a non-final scan beat.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OUT  = 2'd1,
        S_SCAN = 2'd2
    } state_t;

    state_t       r_state, w_state_nxt;
    logic [W-1:0] r_y, w_y_nxt;
    logic         r_last, w_last_nxt;
    logic         r_err, w_err_nxt;
    logic [N-1:0] r_count, w_count_nxt;
    logic [N-1:0] r_target, w_target_nxt;
    logic [N-1:0] w_count_inc;
    logic [W-1:0] w_onehot;
    logic [W-1:0] w_therm;
    logic         w_accept;
    logic         w_xfer;

    // The count never exceeds target (at most W-1), so N bits cannot wrap.
    assign w_count_inc = r_count + 1'b1;
    assign w_onehot    = c_ONE << x;
    // Bits 0..x set: the one-hot bit plus every bit below it.
    assign w_therm     = w_onehot | (w_onehot - c_ONE);

    assign out_valid = (r_state != S_IDLE);
    assign w_xfer    = out_valid && out_ready;
    assign y         = r_y;
    assign out_last  = r_last;
    assign err       = r_err;

    // Next-state, next-word and ready logic; an accept overrides the
    // retire-to-idle decision so back-to-back words leave no bubble.
    always_comb begin
        w_state_nxt  = r_state;
        w_y_nxt      = r_y;
        w_last_nxt   = r_last;
        w_err_nxt    = 1'b0;
        w_count_nxt  = r_count;
        w_target_nxt = r_target;
        in_ready     = 1'b0;
        w_accept     = 1'b0;

        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_OUT: begin
                in_ready = out_ready;
                if (w_xfer) begin
                    w_state_nxt = S_IDLE;
                    w_y_nxt     = '0;
                    w_last_nxt  = 1'b0;
                end
            end
            S_SCAN: begin
                in_ready = 1'b0;
                if (w_xfer) begin
                    w_y_nxt     = r_y << 1;
                    w_count_nxt = w_count_inc;
                    if (w_count_inc == r_target) begin
                        w_state_nxt = S_OUT;
                        w_last_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_y_nxt     = '0;
                w_last_nxt  = 1'b0;
            end
        endcase

        if (rst) begin
            in_ready = 1'b0;
        end

        w_accept = in_valid && in_ready;

        if (w_accept) begin
            case (mode)
                c_MODE_ONEHOT: begin
                    w_state_nxt = S_OUT;
                    w_y_nxt     = w_onehot;
                    w_last_nxt  = 1'b1;
                end
                c_MODE_THERM: begin
                    w_state_nxt = S_OUT;
                    w_y_nxt     = w_therm;
                    w_last_nxt  = 1'b1;
                end
                c_MODE_SCAN: begin
                    w_target_nxt = x;
                    w_count_nxt  = '0;
                    w_y_nxt      = c_ONE;
                    if (x == c_ZERO_N) begin
                        w_state_nxt = S_OUT;
                        w_last_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_SCAN;
                        w_last_nxt  = 1'b0;
                    end
                end
                default: begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_y_nxt     = '0;
                    w_last_nxt  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset aborts any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_y      <= '0;
            r_last   <= 1'b0;
            r_err    <= 1'b0;
            r_count  <= '0;
            r_target <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_y      <= w_y_nxt;
            r_last   <= w_last_nxt;
            r_err    <= w_err_nxt;
            r_count  <= w_count_nxt;
            r_target <= w_target_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decoder_param_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_param_reg
// Description : Self-checking bench for decoder_param_reg at N = 3, 1 and 6.
//               A request-level model predicts every output each cycle; the
//               directed sequences also pin hand-computed literal words.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_decoder_param_reg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance 0: N=3, instance 1: N=1, instance 2: N=6
    logic [2:0] iv;
    logic [2:0] ordy;
    logic [5:0] ix [3];
    logic [1:0] im [3];
    wire  [2:0] ir, ov, ol, er;
    wire  [7:0]  y3;
    wire  [1:0]  y1;
    wire  [63:0] y6;

    decoder_param_reg #(.N(3)) u_n3 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .x(ix[0][2:0]), .mode(im[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .y(y3), .out_last(ol[0]), .err(er[0])
    );
    decoder_param_reg #(.N(1)) u_n1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .x(ix[1][0:0]), .mode(im[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .y(y1), .out_last(ol[1]), .err(er[1])
    );
    decoder_param_reg #(.N(6)) u_n6 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .x(ix[2]), .mode(im[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .y(y6), .out_last(ol[2]), .err(er[2])
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    function automatic logic [63:0] dut_y(int i);
        case (i)
            0:       return {56'd0, y3};
            1:       return {62'd0, y1};
            default: return y6;
        endcase
    endfunction

    task automatic check(string nm, int i, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d @%0t: got %h expected %h", nm, i, $time, act, exp);
        end
    endtask

    // ---------------- request-level model ----------------
    // A busy instance is emitting request (kind, x); for a scan, beat b
    // carries 1<<b and the request ends after beat x.
    bit         m_busy [3];
    logic [1:0] m_kind [3];
    int         m_x    [3];
    int         m_beat [3];
    bit         m_err  [3];

    function automatic logic [63:0] exp_y(int i);
        logic [64:0] t;
        if (!m_busy[i]) return 64'd0;
        case (m_kind[i])
            2'd0:    return 64'd1 << m_x[i];
            2'd1:    begin t = (65'd2 << m_x[i]) - 65'd1; return t[63:0]; end
            default: return 64'd1 << m_beat[i];
        endcase
    endfunction

    function automatic bit exp_last(int i);
        return m_busy[i] && (m_kind[i] != 2'd2 || m_beat[i] == m_x[i]);
    endfunction

    function automatic bit exp_rdy(int i);
        return !rst && (!m_busy[i] || (exp_last(i) && ordy[i]));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_busy[i] <= 1'b0;
                m_err[i]  <= 1'b0;
                m_beat[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                bit acc;
                acc = iv[i] && exp_rdy(i);
                m_err[i] <= acc && (im[i] == 2'd3);
                if (acc) begin
                    if (im[i] == 2'd3) begin
                        m_busy[i] <= 1'b0;
                    end else begin
                        m_busy[i] <= 1'b1;
                        m_kind[i] <= im[i];
                        m_x[i]    <= int'(ix[i]);
                        m_beat[i] <= 0;
                    end
                end else if (m_busy[i] && ordy[i]) begin
                    if (exp_last(i)) m_busy[i] <= 1'b0;
                    else             m_beat[i] <= m_beat[i] + 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check("out_valid", i, 64'(ov[i]), 64'(m_busy[i]));
                check("y",         i, dut_y(i),   exp_y(i));
                check("out_last",  i, 64'(ol[i]), 64'(exp_last(i)));
                check("err",       i, 64'(er[i]), 64'(m_err[i]));
                check("in_ready",  i, 64'(ir[i]), 64'(exp_rdy(i)));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(int i, bit v, logic [1:0] m, int xv, bit r);
        iv[i]   = v;
        im[i]   = m;
        ix[i]   = 6'(xv);
        ordy[i] = r;
    endtask

    // Scan request x with a free-flowing consumer: beats 1<<0 .. 1<<x.
    task automatic scan(int i, int xv);
        drive(i, 1'b1, 2'd2, xv, 1'b1);
        tick();
        drive(i, 1'b0, 2'd2, 0, 1'b1);   // later x changes must not matter
        for (int b = 0; b <= xv; b++) begin
            check("scan_y",     i, dut_y(i),   64'd1 << b);
            check("scan_last",  i, 64'(ol[i]), 64'(b == xv));
            check("scan_ready", i, 64'(ir[i]), 64'(b == xv));
            tick();
        end
        check("scan_done", i, 64'(ov[i]), 64'd0);
    endtask

    initial begin
        rst  = 1'b1;
        iv   = '0;
        ordy = '1;
        for (int i = 0; i < 3; i++) begin
            ix[i] = '0;
            im[i] = '0;
        end
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b1;
        check("rst_in_ready", 0, 64'(ir[0]), 64'd0);
        check("rst_valid",    0, 64'(ov[0]), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rel_in_ready", 0, 64'(ir[0]), 64'd1);

        // One-hot, N=3, x=5
        drive(0, 1'b1, 2'd0, 5, 1'b1);
        tick();
        check("oh_y",     0, dut_y(0),   64'h20);
        check("oh_last",  0, 64'(ol[0]), 64'd1);
        check("oh_valid", 0, 64'(ov[0]), 64'd1);
        drive(0, 1'b0, 2'd0, 0, 1'b1);
        tick();
        check("oh_idle_v", 0, 64'(ov[0]), 64'd0);
        check("oh_idle_y", 0, dut_y(0),   64'd0);

        // Thermometer back-to-back, N=3
        drive(0, 1'b1, 2'd1, 3, 1'b1);
        tick();
        check("th3", 0, dut_y(0), 64'h0F);
        drive(0, 1'b1, 2'd1, 7, 1'b1);
        tick();
        check("th7", 0, dut_y(0), 64'hFF);
        drive(0, 1'b1, 2'd1, 0, 1'b1);
        tick();
        check("th0", 0, dut_y(0), 64'h01);
        drive(0, 1'b0, 2'd0, 0, 1'b1);
        tick();

        // Scan, N=3, x=3
        scan(0, 3);

        // Stall then no-bubble handoff, N=3
        drive(0, 1'b1, 2'd0, 7, 1'b0);
        tick();
        drive(0, 1'b1, 2'd0, 1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check("stall_y",     0, dut_y(0),   64'h80);
            check("stall_ready", 0, 64'(ir[0]), 64'd0);
            tick();
        end
        drive(0, 1'b1, 2'd0, 1, 1'b1);
        #1;
        check("handoff_ready", 0, 64'(ir[0]), 64'd1);
        tick();
        check("handoff_y",    0, dut_y(0),   64'h02);
        check("handoff_last", 0, 64'(ol[0]), 64'd1);
        drive(0, 1'b0, 2'd0, 0, 1'b1);
        tick();

        // Illegal mode
        drive(0, 1'b1, 2'd3, 0, 1'b1);
        tick();
        check("err_pulse", 0, 64'(er[0]), 64'd1);
        check("err_novld", 0, 64'(ov[0]), 64'd0);
        drive(0, 1'b0, 2'd0, 0, 1'b1);
        tick();
        check("err_clear", 0, 64'(er[0]), 64'd0);

        // Reset mid-scan
        drive(0, 1'b1, 2'd2, 5, 1'b1);
        tick();
        drive(0, 1'b0, 2'd0, 0, 1'b1);
        check("mid_y0", 0, dut_y(0), 64'h01);
        tick();
        check("mid_y1", 0, dut_y(0), 64'h02);
        tick();
        check("mid_y2", 0, dut_y(0), 64'h04);
        rst = 1'b1;
        #1;
        check("arst_y",     0, dut_y(0),   64'd0);
        check("arst_valid", 0, 64'(ov[0]), 64'd0);
        check("arst_ready", 0, 64'(ir[0]), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_ready", 0, 64'(ir[0]), 64'd1);
        drive(0, 1'b1, 2'd0, 2, 1'b1);
        tick();
        check("post_rst_y", 0, dut_y(0), 64'h04);
        drive(0, 1'b0, 2'd0, 0, 1'b1);
        tick();

        // N=1
        drive(1, 1'b1, 2'd0, 1, 1'b1);
        tick();
        check("n1_oh", 1, dut_y(1), 64'h2);
        drive(1, 1'b1, 2'd1, 1, 1'b1);
        tick();
        check("n1_th", 1, dut_y(1), 64'h3);
        drive(1, 1'b0, 2'd0, 0, 1'b1);
        tick();
        check("n1_idle", 1, 64'(ov[1]), 64'd0);
        scan(1, 1);
        scan(1, 0);

        // N=6
        drive(2, 1'b1, 2'd0, 40, 1'b1);
        tick();
        check("n6_oh", 2, dut_y(2), 64'h0000_0100_0000_0000);
        drive(2, 1'b1, 2'd1, 63, 1'b1);
        tick();
        check("n6_th", 2, dut_y(2), 64'hFFFF_FFFF_FFFF_FFFF);
        drive(2, 1'b0, 2'd0, 0, 1'b1);
        tick();
        scan(2, 63);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
